// File: rtl/obstacle_scroller_pkg.sv
// Shared constants, types and respawn/collision helpers for the obstacle scroller.
// SPEED_RAMP_EN enables the speed ramp constants.
package obstacle_scroller_pkg;

    typedef logic [7:0] ubyte_t;

    localparam ubyte_t     XMax      = 8'd159;
    localparam ubyte_t     ObsW      = 8'd8;
    localparam ubyte_t     ObsHMin   = 8'd8;
    localparam ubyte_t     MinGap    = 8'd40;
    localparam logic [3:0] BaseSpeed = 4'd1;
    localparam ubyte_t     LfsrSeed  = 8'hA5;

    localparam ubyte_t     GroundTop = 8'd100;
    localparam ubyte_t     DinoLeft  = 8'd16;
    localparam ubyte_t     DinoRight = 8'd24;
    localparam ubyte_t     DinoH     = 8'd16;

`ifdef SPEED_RAMP_EN
    localparam logic [3:0] SpeedMax  = 4'd6;
    localparam int unsigned RampShift = 3;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StCrash} state_e;

    typedef struct packed {
        ubyte_t x;
        ubyte_t h;
    } obs_t;

    // Place a new obstacle behind the other one, never before the right screen edge.
    function automatic obs_t respawn(ubyte_t other_x, logic [4:0] rnd);
        logic [8:0] sum;
        obs_t       o;
        sum = {1'b0, other_x} + {1'b0, MinGap} + {4'b0, rnd};
        if (sum > 9'd255) begin
            o.x = 8'hFF;
        end else if (sum < {1'b0, XMax}) begin
            o.x = XMax;
        end else begin
            o.x = sum[7:0];
        end
        o.h = ObsHMin + {4'b0, rnd[3:0]};
        return o;
    endfunction

    function automatic logic collide(ubyte_t x, ubyte_t h, ubyte_t dino_y);
        logic [8:0] obs_right;
        logic [8:0] dino_bot;
        logic [8:0] obs_top;
        obs_right = {1'b0, x} + {1'b0, ObsW};
        dino_bot  = {1'b0, dino_y} + {1'b0, DinoH};
        obs_top   = {1'b0, GroundTop} - {1'b0, h};
        return (x < DinoRight) && (obs_right > {1'b0, DinoLeft}) && (dino_bot > obs_top);
    endfunction

endpackage

// File: rtl/obstacle_scroller_if.sv
// Control inputs and obstacle/status outputs between the scroller and its environment.
interface obstacle_scroller_if;
    logic       enable;
    logic       frameClk;
    logic       start;
    logic [7:0] dinoY;
    logic [7:0] obs1X;
    logic [7:0] obs2X;
    logic [7:0] obs1H;
    logic [7:0] obs2H;
    logic [7:0] passCount;
    logic [3:0] speed;
    logic       running;
    logic       crashed;
    logic       hit;

    modport master (
        output enable, frameClk, start, dinoY,
        input  obs1X, obs2X, obs1H, obs2H, passCount, speed, running, crashed, hit
    );

    modport slave (
        input  enable, frameClk, start, dinoY,
        output obs1X, obs2X, obs1H, obs2H, passCount, speed, running, crashed, hit
    );
endinterface

// File: rtl/obstacle_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing one step per cycle with step_i high.
module obstacle_lfsr #(
    parameter logic [7:0] Seed = 8'hA5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       step_i,
    output logic [7:0] value_o
);
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_q <= Seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;
endmodule

// File: rtl/obstacle_scroller.sv
// Scrolls two obstacles once per frame tick, respawns them randomly and detects dino collisions.
// Optional speed ramp with passCount is built when SPEED_RAMP_EN is defined.
module obstacle_scroller
    import obstacle_scroller_pkg::*;
(
    input logic                clk,
    input logic                resetn,
    obstacle_scroller_if.slave bus
);
    state_e     state_q, state_d;
    ubyte_t     obs1_x_q, obs1_x_d, obs2_x_q, obs2_x_d;
    ubyte_t     obs1_h_q, obs1_h_d, obs2_h_q, obs2_h_d;
    ubyte_t     pass_q, pass_d;
    logic [3:0] speed_q, speed_d;
    logic       frame_q;
    logic       hit_q, hit_d;
    logic [7:0] lfsr;
    logic       tick, coll, step;
    obs_t       o1, o2;
    logic       n1, n2;
    logic [8:0] pass_sum;
`ifdef SPEED_RAMP_EN
    logic [8:0] ramp;
`endif

    assign tick = bus.enable & bus.frameClk & ~frame_q;
    assign coll = (state_q == StRun) &&
                  (collide(obs1_x_q, obs1_h_q, bus.dinoY) || collide(obs2_x_q, obs2_h_q, bus.dinoY));
    assign step = tick && (state_q == StRun) && !coll;

    obstacle_lfsr #(
        .Seed (LfsrSeed)
    ) u_lfsr (
        .clk     (clk),
        .resetn  (resetn),
        .step_i  (step),
        .value_o (lfsr)
    );

    always_comb begin
        state_d  = state_q;
        obs1_x_d = obs1_x_q;
        obs2_x_d = obs2_x_q;
        obs1_h_d = obs1_h_q;
        obs2_h_d = obs2_h_q;
        pass_d   = pass_q;
        speed_d  = speed_q;
        hit_d    = 1'b0;
        o1       = '0;
        o2       = '0;
        n1       = 1'b0;
        n2       = 1'b0;
        pass_sum = '0;
`ifdef SPEED_RAMP_EN
        ramp     = '0;
`endif
        if (bus.enable) begin
            unique case (state_q)
                StIdle, StCrash: begin
                    // A tick arriving with start is swallowed; scrolling begins next tick.
                    if (bus.start) begin
                        state_d  = StRun;
                        obs1_x_d = XMax;
                        obs2_x_d = XMax + MinGap;
                        obs1_h_d = ObsHMin;
                        obs2_h_d = ObsHMin;
                        pass_d   = '0;
                        speed_d  = BaseSpeed;
                    end
                end
                StRun: begin
                    if (coll) begin
                        state_d = StCrash;
                        hit_d   = 1'b1;
                    end else if (tick) begin
                        if (obs1_x_q < {4'b0, speed_q}) begin
                            o1       = respawn(obs2_x_q, lfsr[4:0]);
                            obs1_x_d = o1.x;
                            obs1_h_d = o1.h;
                            n1       = 1'b1;
                        end else begin
                            obs1_x_d = obs1_x_q - {4'b0, speed_q};
                        end
                        // obs2 draws from the nibble-swapped LFSR and trails obs1's new position.
                        if (obs2_x_q < {4'b0, speed_q}) begin
                            o2       = respawn(obs1_x_d, {lfsr[0], lfsr[7:4]});
                            obs2_x_d = o2.x;
                            obs2_h_d = o2.h;
                            n2       = 1'b1;
                        end else begin
                            obs2_x_d = obs2_x_q - {4'b0, speed_q};
                        end
                        pass_sum = {1'b0, pass_q} + {8'b0, n1} + {8'b0, n2};
                        pass_d   = (pass_sum > 9'd255) ? 8'hFF : pass_sum[7:0];
`ifdef SPEED_RAMP_EN
                        ramp    = {5'b0, BaseSpeed} + {1'b0, pass_d >> RampShift};
                        speed_d = (ramp > {5'b0, SpeedMax}) ? SpeedMax : ramp[3:0];
`endif
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            obs1_x_q <= XMax;
            obs2_x_q <= XMax + MinGap;
            obs1_h_q <= ObsHMin;
            obs2_h_q <= ObsHMin;
            pass_q   <= '0;
            speed_q  <= BaseSpeed;
            frame_q  <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            obs1_x_q <= obs1_x_d;
            obs2_x_q <= obs2_x_d;
            obs1_h_q <= obs1_h_d;
            obs2_h_q <= obs2_h_d;
            pass_q   <= pass_d;
            speed_q  <= speed_d;
            frame_q  <= bus.frameClk;
            hit_q    <= hit_d;
        end
    end

    assign bus.obs1X     = obs1_x_q;
    assign bus.obs2X     = obs2_x_q;
    assign bus.obs1H     = obs1_h_q;
    assign bus.obs2H     = obs2_h_q;
    assign bus.passCount = pass_q;
    assign bus.speed     = speed_q;
    assign bus.running   = (state_q == StRun);
    assign bus.crashed   = (state_q == StCrash);
    assign bus.hit       = hit_q;
endmodule

// File: tb/tb_obstacle_scroller.sv
// Bench for obstacle_scroller: per-cycle comparison against a behavioural game model plus
// hand-computed checkpoints.
module tb_obstacle_scroller;
    localparam int GROUND = 100;
    localparam int DINO_L = 16;
    localparam int DINO_R = 24;
    localparam int DINO_H = 16;
    localparam int OBS_W  = 8;

    logic clk = 1'b1;
    logic resetn;
    always #5 clk = ~clk;

    obstacle_scroller_if bus();

    obstacle_scroller dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 0;
    int hit_cycles = 0;

    // Model state
    int m_x1, m_x2, m_h1, m_h2, m_pass, m_speed, m_lfsr;
    bit m_run, m_crash, m_hit, m_fprev;

    task automatic chk_eq(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bool_hits(input int x, input int h, input int dy);
        return (x < DINO_R) && (x + OBS_W > DINO_L) && (dy + DINO_H > GROUND - h);
    endfunction

    function automatic int place(input int other, input int rnd);
        int p;
        p = other + 40 + (rnd % 32);
        if (p > 255) p = 255;
        if (p < 159) p = 159;
        return p;
    endfunction

    task automatic model_init();
        m_x1 = 159; m_x2 = 199; m_h1 = 8; m_h2 = 8; m_pass = 0; m_speed = 1;
    endtask

    task automatic model_step();
        bit tk, nh;
        int r, r2, fb;
        tk = bus.enable && bus.frameClk && !m_fprev;
        m_fprev = bus.frameClk;
        nh = 0;
        if (!resetn) begin
            model_init();
            m_lfsr = 8'hA5; m_run = 0; m_crash = 0; m_fprev = 0;
        end else if (bus.enable) begin
            if (!m_run) begin
                if (bus.start) begin
                    model_init();
                    m_run = 1; m_crash = 0;
                end
            end else if (bool_hits(m_x1, m_h1, int'(bus.dinoY)) ||
                         bool_hits(m_x2, m_h2, int'(bus.dinoY))) begin
                m_run = 0; m_crash = 1; nh = 1;
            end else if (tk) begin
                r  = m_lfsr;
                r2 = ((r * 16) % 256) + (r / 16);
                if (m_x1 < m_speed) begin
                    m_x1 = place(m_x2, r); m_h1 = 8 + r % 16; m_pass++;
                end else m_x1 -= m_speed;
                if (m_x2 < m_speed) begin
                    m_x2 = place(m_x1, r2); m_h2 = 8 + r2 % 16; m_pass++;
                end else m_x2 -= m_speed;
                if (m_pass > 255) m_pass = 255;
`ifdef SPEED_RAMP_EN
                m_speed = 1 + m_pass / 8;
                if (m_speed > 6) m_speed = 6;
`endif
                fb = ((r >> 7) ^ (r >> 5) ^ (r >> 4) ^ (r >> 3)) & 1;
                m_lfsr = ((r * 2) % 256) | fb;
            end
        end
        m_hit = nh;
    endtask

    // Compare DUT against the model each negedge, then advance the model for the next posedge.
    initial begin
        m_fprev = 0;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk_eq("obs1X", int'(bus.obs1X), m_x1);
                chk_eq("obs2X", int'(bus.obs2X), m_x2);
                chk_eq("obs1H", int'(bus.obs1H), m_h1);
                chk_eq("obs2H", int'(bus.obs2H), m_h2);
                chk_eq("passCount", int'(bus.passCount), m_pass);
                chk_eq("speed", int'(bus.speed), m_speed);
                chk_eq("running", int'(bus.running), int'(m_run));
                chk_eq("crashed", int'(bus.crashed), int'(m_crash));
                chk_eq("hit", int'(bus.hit), int'(m_hit));
                if (bus.hit) hit_cycles++;
            end
            model_step();
        end
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frameClk = 1'b1;
            clk1();
            bus.frameClk = 1'b0;
            clk1();
        end
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        bus.enable = 1'b1; bus.frameClk = 1'b0; bus.start = 1'b0; bus.dinoY = 8'd0;
        clk1();
        chk_on = 1;
        chk_eq("rst_obs1X", int'(bus.obs1X), 159);
        chk_eq("rst_obs2X", int'(bus.obs2X), 199);
        chk_eq("rst_obs1H", int'(bus.obs1H), 8);
        chk_eq("rst_obs2H", int'(bus.obs2H), 8);
        chk_eq("rst_pass", int'(bus.passCount), 0);
        chk_eq("rst_running", int'(bus.running), 0);
        resetn = 1'b1;
        clk1(); clk1();

        // Start and scroll ten frames with the dino high above.
        bus.start = 1'b1; clk1(); bus.start = 1'b0;
        chk_eq("start_running", int'(bus.running), 1);
        tick_n(10);
        chk_eq("t10_obs1X", int'(bus.obs1X), 149);
        chk_eq("t10_obs2X", int'(bus.obs2X), 189);
        repeat (6) clk1();
        chk_eq("hold_obs1X", int'(bus.obs1X), 149);

        // Drive obs1 off the left edge and check the first respawn.
        tick_n(149);
        chk_eq("edge_obs1X", int'(bus.obs1X), 0);
        tick_n(1);
        chk_eq("resp_x_ge", int'(bus.obs1X >= 8'd159), 1);
        chk_eq("resp_h_rng", int'(bus.obs1H >= 8'd8 && bus.obs1H <= 8'd23), 1);
        chk_eq("resp_pass", int'(bus.passCount), 1);
        tick_n(200);

        // Dino on the ground: run into an obstacle.
        bus.dinoY = 8'(GROUND - DINO_H);
        n = 0;
        while (!bus.crashed && n < 300) begin
            tick_n(1);
            n++;
        end
        chk_eq("crash_reached", int'(bus.crashed), 1);
        tick_n(4);
        chk_eq("crash_held", int'(bus.crashed), 1);
        chk_eq("crash_not_run", int'(bus.running), 0);
        chk_eq("hit_one_cycle", hit_cycles, 1);
`ifndef SPEED_RAMP_EN
        chk_eq("speed_const", int'(bus.speed), 1);
`endif

        // Restart together with a frame edge: re-init only.
        bus.frameClk = 1'b1; bus.start = 1'b1;
        clk1();
        bus.frameClk = 1'b0; bus.start = 1'b0; bus.dinoY = 8'd0;
        chk_eq("restart_obs1X", int'(bus.obs1X), 159);
        chk_eq("restart_obs2X", int'(bus.obs2X), 199);
        chk_eq("restart_pass", int'(bus.passCount), 0);
        chk_eq("restart_running", int'(bus.running), 1);
        clk1();
        tick_n(3);
        chk_eq("t3_obs1X", int'(bus.obs1X), 156);

        // Enable low freezes everything, including start.
        bus.enable = 1'b0;
        bus.start = 1'b1; clk1(); bus.start = 1'b0;
        tick_n(5);
        chk_eq("frz_obs1X", int'(bus.obs1X), 156);
        chk_eq("frz_obs2X", int'(bus.obs2X), 196);
        chk_eq("frz_running", int'(bus.running), 1);
        bus.enable = 1'b1;
        clk1();
        tick_n(2);
        chk_eq("t2_obs1X", int'(bus.obs1X), 154);

        // Reset in the middle of a run.
        resetn = 1'b0; clk1();
        chk_eq("mrst_obs1X", int'(bus.obs1X), 159);
        chk_eq("mrst_obs2X", int'(bus.obs2X), 199);
        chk_eq("mrst_running", int'(bus.running), 0);
        resetn = 1'b1;
        clk1(); clk1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
